pipe_stall_ctrl: RTL
====================

# pipe_stall_ctrl

Pipeline sequencing controller for the 5-stage core. Turns the decode-stage RAW hazard flag, the EX-stage control-flow redirect and the data-memory handshake into per-stage write-enable and flush strobes. Tracks multi-cycle stall and redirect episodes with a small state machine, and keeps saturating stall/flush performance counters plus a stall watchdog. Sits beside the hazard detector and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
- REDIRECT_BUBBLES, 1: extra fetch slots squashed after a redirect, to cover I-mem read latency; legal 0..3.
- MAX_STALL, 15: consecutive RAW-stall cycles before the watchdog trips; legal 1..255.
- CNT_W, 32: width of the performance counters.

- clk_i  in  1  core clock, rising edge
- rst_n_i  in  1  reset; one clock, asynchronous, active-low
- hazard_i  in  1  RAW hazard flag from the hazard detector (ID stage)
- redirect_i  in  1  taken branch / JAL / JALR resolved in EX; PC mux already selects the target
- dmem_req_i  in  1  MEM stage issuing a load/store this cycle
- dmem_ready_i  in  1  data memory accepts/completes the access this cycle
- pc_we_o  out  1  PC register load enable
- if_id_we_o  out  1  IF/ID register enable
- id_ex_we_o  out  1  ID/EX register enable
- ex_mem_we_o  out  1  EX/MEM register enable
- if_id_flush_o  out  1  load bubble into IF/ID
- id_ex_flush_o  out  1  load bubble into ID/EX
- mem_wb_flush_o  out  1  load bubble into MEM/WB
- state_o  out  2  current state: 0 RUN, 1 RAW_STALL, 2 MEM_WAIT, 3 REDIRECT
- stall_cnt_o  out  CNT_W  cycles with pc_we_o=0, saturating
- flush_cnt_o  out  CNT_W  accepted redirect events, saturating
- watchdog_o  out  1  sticky, set when a RAW stall exceeds MAX_STALL cycles

## Operation
- Define mem_block = dmem_req_i & ~dmem_ready_i.
- Outputs are combinational from state and current inputs.
- State, bubble counter, stall-run counter, perf counters and watchdog are registered.
- Event priority per cycle: mem_block > redirect_i > REDIRECT state > hazard_i > normal.
- mem_block:
  - All four write enables are 0, mem_wb_flush_o=1, other flushes 0.
  - Next state MEM_WAIT.
  - A redirect_i present at the same time is not lost: EX is frozen, so it stays asserted and is taken on the first unblocked cycle.
- redirect_i (unblocked):
  - pc_we_o=1, if_id_we_o=1, id_ex_we_o=1, ex_mem_we_o=1, if_id_flush_o=1, id_ex_flush_o=1.
  - flush_cnt_o increments.
  - If REDIRECT_BUBBLES=0, next state RUN; otherwise bubble counter loads REDIRECT_BUBBLES and next state is REDIRECT.
- REDIRECT (no new redirect, unblocked):
  - Enables all 1; if_id_flush_o=1 and id_ex_flush_o=1.
  - hazard_i is ignored.
  - Counter decrements; at 1, next state RUN.
  - A new redirect_i restarts the counter and counts again.
- hazard_i (state RUN/RAW_STALL/MEM_WAIT, unblocked, no redirect):
  - pc_we_o=0, if_id_we_o=0, id_ex_flush_o=1, id_ex_we_o=1, ex_mem_we_o=1.
  - Next state RAW_STALL; stall-run counter increments, saturating at 255.
  - When the run length reaches MAX_STALL+1, watchdog_o sets and holds until reset.
- Normal: all enables 1, all flushes 0, next state RUN, stall-run counter clears.
- The stall-run counter also clears on any cycle not in RAW stall.
- stall_cnt_o increments on every cycle with pc_we_o=0 (RAW and MEM stalls).
- Both perf counters saturate at all-ones and never wrap.

## Timing
- Zero-cycle latency from inputs to stage strobes (same-cycle combinational).
- Registered state/counters update on the rising clk_i.
- While rst_n_i=0, asynchronously:
  - state=RUN, counters=0, watchdog_o=0.
  - All write enables 0; all flushes 1; state_o=0.
- Reset released mid-redirect or mid-stall: the controller restarts in RUN with nothing pending.
- RAW against an EX-stage producer with no forwarding stalls 2 cycles; against a MEM-stage producer, 1 cycle.
- A redirect occupies 1+REDIRECT_BUBBLES squash cycles.
- Memory handshake: the pipeline stays frozen for exactly the cycles with dmem_req_i=1 and dmem_ready_i=0.
  - The cycle ready rises is a normal advance cycle, subject to the remaining priorities.

## Test plan
- RAW stall:
  - Stimulus: hazard_i=1 for 2 cycles, then 0.
  - Response: pc_we_o=if_id_we_o=0 and id_ex_flush_o=1 for both cycles; state_o 1,1,0; stall_cnt_o=2; watchdog_o=0.
- Redirect squash:
  - Stimulus: REDIRECT_BUBBLES=2, redirect_i pulse of 1 cycle.
  - Response: if_id_flush_o=1 for 3 cycles; state_o 3,3 then 0; flush_cnt_o=1; hazard_i=1 during cycles 2-3 produces no stall.
- Memory freeze with pending redirect:
  - Stimulus: dmem_req_i=1, dmem_ready_i=0 for 3 cycles, redirect_i held 1 throughout, then ready=1.
  - Response: all enables 0 and mem_wb_flush_o=1 for 3 cycles; the redirect is taken on the ready cycle; flush_cnt_o=1.
- Watchdog:
  - Stimulus: MAX_STALL=4, hazard_i held for 6 cycles.
  - Response: watchdog_o rises after the 5th stall cycle and stays 1 after hazard_i drops.
- Reset mid-operation:
  - Stimulus: assert rst_n_i=0 asynchronously in the REDIRECT state.
  - Response: immediately state_o=0, counters=0, enables 0, flushes 1; after release with idle inputs, all enables 1.
- Counter saturation:
  - Stimulus: CNT_W=4, 20 stall cycles.
  - Response: stall_cnt_o holds at 15 with no wrap.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
// Pipeline sequencing controller for the 5-stage core. Combines the ID-stage
// RAW hazard flag, the EX-stage redirect and the data-memory handshake into
// per-stage write enables and flush strobes. It also keeps saturating
// stall/flush performance counters and a sticky RAW-stall watchdog.
//
// Ports:
//   clk_i          core clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   hazard_i       RAW hazard flag from the hazard detector
//   redirect_i     taken branch / JAL / JALR resolved in EX
//   dmem_req_i     MEM stage issues a load/store this cycle
//   dmem_ready_i   data memory accepts/completes the access this cycle
//   pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o   pipeline register enables
//   if_id_flush_o, id_ex_flush_o, mem_wb_flush_o   bubble-insert strobes
//   state_o        0 RUN, 1 RAW_STALL, 2 MEM_WAIT, 3 REDIRECT
//   stall_cnt_o    cycles with pc_we_o=0, saturating
//   flush_cnt_o    accepted redirects, saturating
//   watchdog_o     sticky: a RAW stall ran longer than MAX_STALL cycles
module pipe_stall_ctrl #(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MAX_STALL        = 15,
  parameter int CNT_W            = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             hazard_i,
  input  logic             redirect_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_we_o,
  output logic             if_id_we_o,
  output logic             id_ex_we_o,
  output logic             ex_mem_we_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             mem_wb_flush_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             watchdog_o
);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_RAW = 2'd1,
    ST_MEM = 2'd2,
    ST_RED = 2'd3
  } state_e;

  localparam logic [1:0] BUBBLES  = 2'(REDIRECT_BUBBLES);
  // Trip point compared against the 9-bit run length including this cycle.
  localparam logic [8:0] WD_LIMIT = 9'(MAX_STALL + 1);

  state_e           state_r, state_next_s;
  logic [1:0]       bubble_r, bubble_next_s;
  logic [7:0]       run_r, run_next_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic             watchdog_r;

  logic             mem_block_s;
  logic             take_redirect_s;
  logic             wd_trip_s;
  logic [8:0]       run_inc_s;
  logic             pc_we_s, if_id_we_s, id_ex_we_s, ex_mem_we_s;
  logic             if_id_flush_s, id_ex_flush_s, mem_wb_flush_s;

  assign mem_block_s = dmem_req_i & ~dmem_ready_i;
  assign run_inc_s   = {1'b0, run_r} + 9'd1;

  // Prioritised strobe decode and next-state selection.
  always_comb begin
    pc_we_s         = 1'b1;
    if_id_we_s      = 1'b1;
    id_ex_we_s      = 1'b1;
    ex_mem_we_s     = 1'b1;
    if_id_flush_s   = 1'b0;
    id_ex_flush_s   = 1'b0;
    mem_wb_flush_s  = 1'b0;
    state_next_s    = ST_RUN;
    bubble_next_s   = bubble_r;
    run_next_s      = 8'd0;
    take_redirect_s = 1'b0;
    wd_trip_s       = 1'b0;

    if (!rst_n_i) begin
      // Hold every stage and bubble everything while in reset.
      pc_we_s        = 1'b0;
      if_id_we_s     = 1'b0;
      id_ex_we_s     = 1'b0;
      ex_mem_we_s    = 1'b0;
      if_id_flush_s  = 1'b1;
      id_ex_flush_s  = 1'b1;
      mem_wb_flush_s = 1'b1;
    end else if (mem_block_s) begin
      // Freeze the whole pipe; a concurrent redirect stays held in EX.
      pc_we_s        = 1'b0;
      if_id_we_s     = 1'b0;
      id_ex_we_s     = 1'b0;
      ex_mem_we_s    = 1'b0;
      mem_wb_flush_s = 1'b1;
      state_next_s   = ST_MEM;
    end else if (redirect_i) begin
      if_id_flush_s   = 1'b1;
      id_ex_flush_s   = 1'b1;
      take_redirect_s = 1'b1;
      if (BUBBLES == 2'd0) begin
        state_next_s = ST_RUN;
      end else begin
        bubble_next_s = BUBBLES;
        state_next_s  = ST_RED;
      end
    end else if (state_r == ST_RED) begin
      // Squash slots still in flight from the old path; hazards are moot.
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
      if (bubble_r <= 2'd1) begin
        bubble_next_s = 2'd0;
        state_next_s  = ST_RUN;
      end else begin
        bubble_next_s = bubble_r - 2'd1;
        state_next_s  = ST_RED;
      end
    end else if (hazard_i) begin
      // Hold PC and IF/ID, push a bubble into ID/EX.
      pc_we_s       = 1'b0;
      if_id_we_s    = 1'b0;
      id_ex_flush_s = 1'b1;
      state_next_s  = ST_RAW;
      run_next_s    = run_inc_s[8] ? 8'd255 : run_inc_s[7:0];
      wd_trip_s     = (run_inc_s >= WD_LIMIT);
    end else begin
      state_next_s = ST_RUN;
    end
  end

  // State, bubble/run counters, perf counters and watchdog.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r     <= ST_RUN;
      bubble_r    <= 2'd0;
      run_r       <= 8'd0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
      watchdog_r  <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      bubble_r <= bubble_next_s;
      run_r    <= run_next_s;
      if (!pc_we_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (take_redirect_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
      if (wd_trip_s) begin
        watchdog_r <= 1'b1;
      end else begin
        watchdog_r <= watchdog_r;
      end
    end
  end

  assign pc_we_o        = pc_we_s;
  assign if_id_we_o     = if_id_we_s;
  assign id_ex_we_o     = id_ex_we_s;
  assign ex_mem_we_o    = ex_mem_we_s;
  assign if_id_flush_o  = if_id_flush_s;
  assign id_ex_flush_o  = id_ex_flush_s;
  assign mem_wb_flush_o = mem_wb_flush_s;
  assign state_o        = state_r;
  assign stall_cnt_o    = stall_cnt_r;
  assign flush_cnt_o    = flush_cnt_r;
  assign watchdog_o     = watchdog_r;

endmodule
